seg_ticker: RTL and testbench
=============================

// Module: seg_ticker
// PURPOSE
//  Parametrised seven-segment message ticker for the board HEX displays.
//  Holds a writable message buffer and scrolls it across NUM_DIGITS digits, one position per step strobe.
//  Selectable direction, looping with a blank gap, one-shot drain, and pause.
//  Sits between the board key/clock-enable logic and the HEX outputs.
// PARAMETERS
//  NUM_DIGITS  4   number of displayed digits
//  MSG_DEPTH   16  message buffer entries; pointer width = $clog2(MSG_DEPTH)
//  GAP         1   blank positions inserted between repetitions in loop mode (0 allowed)
//  SEG_W       7   segment pattern width, active-low (7'h7F = blank)
// PORTS
//  clk      in   1                 clock
//  reset    in   1                 asynchronous, active-low reset
//  clear    in   1                 sync abort: to IDLE, display blanked
//  start    in   1                 begin scroll (accepted in IDLE/DONE only)
//  msg_len  in   $clog2(MSG_DEPTH)+1  chars to show, 1..MSG_DEPTH, latched on start
//  loop     in   1                 1 = repeat forever, 0 = one-shot; latched on start
//  dir      in   1                 0 = enter right/move left, 1 = enter left/move right; latched
//  step     in   1                 one-cycle scroll strobe
//  pause    in   1                 1 = step ignored, state frozen
//  wr_en    in   1                 message buffer write
//  wr_addr  in   $clog2(MSG_DEPTH) write address
//  wr_data  in   SEG_W             segment pattern to store
//  digits   out  NUM_DIGITS*SEG_W  digit k at [k*SEG_W +: SEG_W]; digit 0 rightmost
//  busy     out  1                 high in RUN/DRAIN
//  lock     out  1                 high while RUN with loop=1 (message wrapped at least once)
//  done     out  1                 high in DONE
// BEHAVIOUR
//  Reset: digits all 7'h7F, state IDLE, busy/lock/done 0, ptr 0; buffer contents undefined.
//  States: IDLE, RUN, DRAIN, DONE. Transitions only on clk edge.
//  IDLE/DONE + start, msg_len in 1..MSG_DEPTH -> RUN, ptr=0, done=0. msg_len 0 or >MSG_DEPTH: start ignored.
//  start in RUN/DRAIN ignored. clear beats start and step; clear in any state -> IDLE, blank.
//  RUN, step & !pause: shift by one; inserted char = mem[ptr] if ptr<msg_len else 7'h7F.
//   dir=0: digit[k]<=digit[k-1], digit[0]<=ins. dir=1: digit[k]<=digit[k+1], digit[N-1]<=ins.
//  ptr advances 0..msg_len+GAP-1 (loop=1); at the last position wraps to 0 and sets lock.
//  loop=0: after ptr msg_len-1 -> DRAIN; GAP unused.
//  DRAIN: NUM_DIGITS more steps insert 7'h7F; after the last -> DONE.
//  DONE: display (all blank) held; done=1 until start or clear.
//  Zero-latency output: digits is a register and updates on the step edge.
//  No pending steps: step while paused is lost.
//  Write port usable in any state; write commits at the edge.
//   Same-cycle write+read of one address inserts OLD data.
//  Reset mid-scroll: immediate return to reset values.
// STRUCTURE
//  Package seg_ticker_pkg: state enum; SEG_BLANK=7'h7F; glyphs H=7'h09, E=7'h06, L=7'h47, O=7'h40.
//  Sub-module seg_ticker_msg_mem: MSG_DEPTH x SEG_W register file.
//   One sync write port, one combinational read port.
//  Top level: FSM, ptr/drain counter, digit shift register.
// TESTING
//  Shown as d3..d0, "_" = blank, NUM_DIGITS=4, GAP=1.
//  Load HELLO, msg_len=5, loop=1, dir=0, 5 steps -> E L L O; step 6 -> L L O _;
//   step 7 -> L O _ H and lock=1.
//  Same message, loop=0 -> after step 5 E L L O, state DRAIN.
//   After step 9 -> all blank, done=1, busy=0.
//  dir=1, HELLO, loop=0, 5 steps -> O L L E.
//  pause=1 with 3 steps mid-RUN -> digits and ptr unchanged.
//   Then clear coincident with step -> all blank, IDLE.
//  start with msg_len=0 -> stays IDLE. start during RUN -> ignored.
//   reset pulse mid-RUN -> all 7'h7F, busy=0.
//  Write addr 4 = 7'h40 in the cycle that reads addr 4 -> old value inserted.
//   The next lap inserts 7'h40.

Source files
------------

// File: rtl/seg_ticker_pkg.sv
// Shared types and constants for the seven-segment message ticker.
package seg_ticker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Segment patterns are active-low: all ones lights nothing.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_H = 7'h09;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_L = 7'h47;
    localparam logic [6:0] GLYPH_O = 7'h40;

endpackage

// File: rtl/seg_ticker_if.sv
// Control, message-write and display signals between the key logic and the ticker.
interface seg_ticker_if #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int SEG_W      = 7
);
    logic                           clear;
    logic                           start;
    logic [$clog2(MSG_DEPTH):0]     msg_len;
    logic                           loop;
    logic                           dir;
    logic                           step;
    logic                           pause;
    logic                           wr_en;
    logic [$clog2(MSG_DEPTH)-1:0]   wr_addr;
    logic [SEG_W-1:0]               wr_data;
    logic [NUM_DIGITS*SEG_W-1:0]    digits;
    logic                           busy;
    logic                           lock;
    logic                           done;

    modport master (
        output clear, start, msg_len, loop, dir, step, pause, wr_en, wr_addr, wr_data,
        input  digits, busy, lock, done
    );

    modport slave (
        input  clear, start, msg_len, loop, dir, step, pause, wr_en, wr_addr, wr_data,
        output digits, busy, lock, done
    );

endinterface

// File: rtl/seg_ticker_msg_mem.sv
// Message buffer: one synchronous write port, one combinational read port.
// A read of the address being written in the same cycle returns the old entry.
module seg_ticker_msg_mem #(
    parameter int MSG_DEPTH = 16,
    parameter int SEG_W     = 7
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [SEG_W-1:0]             wr_data,
    input  logic [$clog2(MSG_DEPTH)-1:0] rd_addr,
    output logic [SEG_W-1:0]             rd_data
);

    logic [SEG_W-1:0] mem_q [MSG_DEPTH];
    logic [SEG_W-1:0] mem_d [MSG_DEPTH];

    // Next buffer contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Buffer storage; contents are deliberately left without reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/seg_ticker.sv
// Seven-segment message ticker: scrolls a stored message across the HEX digits.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | display blank, waiting for a valid start
//   ST_RUN   | each step shifts in mem[ptr], or blank in the gap/past the end
//   ST_DRAIN | one-shot tail: NUM_DIGITS blank steps push the message out
//   ST_DONE  | display blank and held, done asserted until start or clear
module seg_ticker #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int GAP        = 1,
    parameter int SEG_W      = 7
) (
    input  logic        clk,
    input  logic        reset,
    seg_ticker_if.slave bus
);
    import seg_ticker_pkg::*;

    localparam int PTR_W = $clog2(MSG_DEPTH);
    localparam int LEN_W = PTR_W + 1;
    localparam int DW    = NUM_DIGITS * SEG_W;
    // The counter walks message + gap positions in RUN and counts down the drain.
    localparam int CNT_W = $clog2(MSG_DEPTH + GAP + NUM_DIGITS + 1);

    localparam logic [SEG_W-1:0] BLANK     = SEG_W'(SEG_BLANK);
    localparam logic [DW-1:0]    ALL_BLANK = {NUM_DIGITS{BLANK}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loop_q, loop_d;
    logic              dir_q, dir_d;
    logic              lock_q, lock_d;
    logic [DW-1:0]     digits_q, digits_d;

    logic [SEG_W-1:0]  rd_data;
    logic [SEG_W-1:0]  ins;
    logic [DW-1:0]     shifted;
    logic [CNT_W-1:0]  len_ext;
    logic              len_ok;
    logic              step_ok;

    seg_ticker_msg_mem #(
        .MSG_DEPTH (MSG_DEPTH),
        .SEG_W     (SEG_W)
    ) u_msg_mem (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (cnt_q[PTR_W-1:0]),
        .rd_data (rd_data)
    );

    assign len_ext = CNT_W'(len_q);
    assign len_ok  = (bus.msg_len != '0) && (bus.msg_len <= LEN_W'(MSG_DEPTH));
    assign step_ok = bus.step && !bus.pause;

    // Character entering the display and the display after one shift.
    always_comb begin
        ins = BLANK;
        if ((state_q == ST_RUN) && (cnt_q < len_ext)) begin
            ins = rd_data;
        end
        if (dir_q) begin
            shifted = {ins, digits_q[DW-1:SEG_W]};
        end else begin
            shifted = {digits_q[DW-SEG_W-1:0], ins};
        end
    end

    // Next-state logic: clear wins over everything, start only from IDLE/DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        loop_d   = loop_q;
        dir_d    = dir_q;
        lock_d   = lock_q;
        digits_d = digits_q;

        if (bus.clear) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            lock_d   = 1'b0;
            digits_d = ALL_BLANK;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start && len_ok) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        lock_d  = 1'b0;
                        len_d   = bus.msg_len;
                        loop_d  = bus.loop;
                        dir_d   = bus.dir;
                    end
                end
                ST_RUN: begin
                    if (step_ok) begin
                        digits_d = shifted;
                        if (loop_q) begin
                            if (cnt_q == len_ext + CNT_W'(GAP) - CNT_W'(1)) begin
                                cnt_d  = '0;
                                lock_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else if (cnt_q == len_ext - CNT_W'(1)) begin
                            state_d = ST_DRAIN;
                            cnt_d   = CNT_W'(NUM_DIGITS - 1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (step_ok) begin
                        digits_d = shifted;
                        if (cnt_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter, latched settings and display register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            dir_q    <= 1'b0;
            lock_q   <= 1'b0;
            digits_q <= ALL_BLANK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            dir_q    <= dir_d;
            lock_q   <= lock_d;
            digits_q <= digits_d;
        end
    end

    assign bus.digits = digits_q;
    assign bus.busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.lock   = lock_q;
    assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_seg_ticker.sv
`timescale 1ns/1ps
module tb_seg_ticker;
    import seg_ticker_pkg::*;

    localparam int ND = 4;
    localparam int MD = 16;
    localparam int SW = 7;
    localparam int DW = ND * SW;

    localparam logic [6:0] B = SEG_BLANK;
    localparam logic [6:0] H = GLYPH_H;
    localparam logic [6:0] E = GLYPH_E;
    localparam logic [6:0] L = GLYPH_L;
    localparam logic [6:0] O = GLYPH_O;

    typedef struct {
        string         name;
        bit            start;
        logic [4:0]    msg_len;
        bit            loop;
        bit            dir;
        bit            step;
        bit            pause;
        bit            clear;
        logic [DW-1:0] exp_digits;
        logic          exp_busy;
        logic          exp_lock;
        logic          exp_done;
    } vec_t;

    typedef struct {
        string         name;
        logic [DW-1:0] digits;
        logic          busy;
        logic          lock;
        logic          done;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[$];
    exp_t sb[$];

    seg_ticker_if #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .SEG_W(SW)) bus ();

    seg_ticker #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .GAP(1), .SEG_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    function automatic logic [DW-1:0] mk(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t vec(input string nm, input bit st, input int len, input bit lp,
                                 input bit dr, input bit sp, input bit pa, input bit cl,
                                 input logic [DW-1:0] d, input bit bz, input bit lk, input bit dn);
        vec_t v;
        v.name = nm; v.start = st; v.msg_len = 5'(len); v.loop = lp; v.dir = dr;
        v.step = sp; v.pause = pa; v.clear = cl;
        v.exp_digits = d; v.exp_busy = bz; v.exp_lock = lk; v.exp_done = dn;
        return v;
    endfunction

    task automatic row(input string nm, input bit st, input int len, input bit lp, input bit dr,
                       input bit sp, input bit pa, input bit cl,
                       input logic [DW-1:0] d, input bit bz, input bit lk, input bit dn);
        tbl.push_back(vec(nm, st, len, lp, dr, sp, pa, cl, d, bz, lk, dn));
    endtask

    task automatic idle_inputs();
        bus.clear = 0; bus.start = 0; bus.msg_len = '0; bus.loop = 0; bus.dir = 0;
        bus.step = 0; bus.pause = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    endtask

    task automatic expect_now(input string nm, input logic [DW-1:0] d, input logic bz,
                              input logic lk, input logic dn);
        exp_t e;
        e.name = nm; e.digits = d; e.busy = bz; e.lock = lk; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic check_next();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e = sb.pop_front();
            if (bus.digits !== e.digits || bus.busy !== e.busy ||
                bus.lock !== e.lock || bus.done !== e.done) begin
                n_fail++;
                $display("FAIL %s: got digits=%h busy=%b lock=%b done=%b, expected digits=%h busy=%b lock=%b done=%b",
                         e.name, bus.digits, bus.busy, bus.lock, bus.done,
                         e.digits, e.busy, e.lock, e.done);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        bus.start = v.start; bus.msg_len = v.msg_len; bus.loop = v.loop; bus.dir = v.dir;
        bus.step = v.step; bus.pause = v.pause; bus.clear = v.clear;
        expect_now(v.name, v.exp_digits, v.exp_busy, v.exp_lock, v.exp_done);
        @(posedge clk); #1;
        idle_inputs();
        check_next();
    endtask

    task automatic write_mem(input int addr, input logic [6:0] data);
        bus.wr_en = 1; bus.wr_addr = 4'(addr); bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_en = 0;
    endtask

    initial begin
        logic [6:0] hello [5];
        hello[0] = H; hello[1] = E; hello[2] = L; hello[3] = L; hello[4] = O;

        // Looping, dir=0, with pause, start-while-running and clear racing step/start.
        row("a_start",     1, 5, 1, 0, 0, 0, 0, mk(B,B,B,B), 1, 0, 0);
        row("a_s1",        0, 0, 0, 0, 1, 0, 0, mk(B,B,B,H), 1, 0, 0);
        row("a_s2",        0, 0, 0, 0, 1, 0, 0, mk(B,B,H,E), 1, 0, 0);
        row("a_s3",        0, 0, 0, 0, 1, 0, 0, mk(B,H,E,L), 1, 0, 0);
        row("a_s4",        0, 0, 0, 0, 1, 0, 0, mk(H,E,L,L), 1, 0, 0);
        row("a_s5",        0, 0, 0, 0, 1, 0, 0, mk(E,L,L,O), 1, 0, 0);
        row("a_s6_gap",    0, 0, 0, 0, 1, 0, 0, mk(L,L,O,B), 1, 1, 0);
        row("a_s7_wrap",   0, 0, 0, 0, 1, 0, 0, mk(L,O,B,H), 1, 1, 0);
        row("a_s8",        0, 0, 0, 0, 1, 0, 0, mk(O,B,H,E), 1, 1, 0);
        row("a_pause1",    0, 0, 0, 0, 1, 1, 0, mk(O,B,H,E), 1, 1, 0);
        row("a_pause2",    0, 0, 0, 0, 1, 1, 0, mk(O,B,H,E), 1, 1, 0);
        row("a_pause3",    0, 0, 0, 0, 1, 1, 0, mk(O,B,H,E), 1, 1, 0);
        row("a_resume",    0, 0, 0, 0, 1, 0, 0, mk(B,H,E,L), 1, 1, 0);
        row("a_start_run", 1, 3, 0, 1, 0, 0, 0, mk(B,H,E,L), 1, 1, 0);
        row("a_after_ign", 0, 0, 0, 0, 1, 0, 0, mk(H,E,L,L), 1, 1, 0);
        row("a_clear",     1, 5, 1, 0, 1, 0, 1, mk(B,B,B,B), 0, 0, 0);
        // One-shot, dir=0, through drain to done.
        row("b_start",     1, 5, 0, 0, 0, 0, 0, mk(B,B,B,B), 1, 0, 0);
        row("b_s1",        0, 0, 0, 0, 1, 0, 0, mk(B,B,B,H), 1, 0, 0);
        row("b_s2",        0, 0, 0, 0, 1, 0, 0, mk(B,B,H,E), 1, 0, 0);
        row("b_s3",        0, 0, 0, 0, 1, 0, 0, mk(B,H,E,L), 1, 0, 0);
        row("b_s4",        0, 0, 0, 0, 1, 0, 0, mk(H,E,L,L), 1, 0, 0);
        row("b_s5",        0, 0, 0, 0, 1, 0, 0, mk(E,L,L,O), 1, 0, 0);
        row("b_drain1",    0, 0, 0, 0, 1, 0, 0, mk(L,L,O,B), 1, 0, 0);
        row("b_drain2",    0, 0, 0, 0, 1, 0, 0, mk(L,O,B,B), 1, 0, 0);
        row("b_drain3",    0, 0, 0, 0, 1, 0, 0, mk(O,B,B,B), 1, 0, 0);
        row("b_done",      0, 0, 0, 0, 1, 0, 0, mk(B,B,B,B), 0, 0, 1);
        row("b_done_hold", 0, 0, 0, 0, 1, 0, 0, mk(B,B,B,B), 0, 0, 1);
        // One-shot, dir=1, restarted straight from DONE.
        row("c_start",     1, 5, 0, 1, 0, 0, 0, mk(B,B,B,B), 1, 0, 0);
        row("c_s1",        0, 0, 0, 0, 1, 0, 0, mk(H,B,B,B), 1, 0, 0);
        row("c_s2",        0, 0, 0, 0, 1, 0, 0, mk(E,H,B,B), 1, 0, 0);
        row("c_s3",        0, 0, 0, 0, 1, 0, 0, mk(L,E,H,B), 1, 0, 0);
        row("c_s4",        0, 0, 0, 0, 1, 0, 0, mk(L,L,E,H), 1, 0, 0);
        row("c_s5",        0, 0, 0, 0, 1, 0, 0, mk(O,L,L,E), 1, 0, 0);
        row("c_clear",     0, 0, 0, 0, 0, 0, 1, mk(B,B,B,B), 0, 0, 0);
        // Invalid lengths and idle steps.
        row("d_len0",      1, 0, 1, 0, 0, 0, 0, mk(B,B,B,B), 0, 0, 0);
        row("d_len17",     1, 17, 1, 0, 0, 0, 0, mk(B,B,B,B), 0, 0, 0);
        row("d_idle_step", 0, 0, 0, 0, 1, 0, 0, mk(B,B,B,B), 0, 0, 0);

        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset_state", mk(B,B,B,B), 0, 0, 0);
        check_next();
        reset = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) write_mem(i, hello[i]);

        foreach (tbl[i]) drive(tbl[i]);

        // Write colliding with the read of the same address: old entry shows, new one next lap.
        write_mem(4, L);
        drive(vec("w_start", 1, 5, 1, 0, 0, 0, 0, mk(B,B,B,B), 1, 0, 0));
        drive(vec("w_s1", 0, 0, 0, 0, 1, 0, 0, mk(B,B,B,H), 1, 0, 0));
        drive(vec("w_s2", 0, 0, 0, 0, 1, 0, 0, mk(B,B,H,E), 1, 0, 0));
        drive(vec("w_s3", 0, 0, 0, 0, 1, 0, 0, mk(B,H,E,L), 1, 0, 0));
        drive(vec("w_s4", 0, 0, 0, 0, 1, 0, 0, mk(H,E,L,L), 1, 0, 0));
        bus.wr_en = 1; bus.wr_addr = 4'd4; bus.wr_data = O;
        drive(vec("w_s5_old", 0, 0, 0, 0, 1, 0, 0, mk(E,L,L,L), 1, 0, 0));
        drive(vec("w_s6", 0, 0, 0, 0, 1, 0, 0, mk(L,L,L,B), 1, 1, 0));
        drive(vec("w_s7", 0, 0, 0, 0, 1, 0, 0, mk(L,L,B,H), 1, 1, 0));
        drive(vec("w_s8", 0, 0, 0, 0, 1, 0, 0, mk(L,B,H,E), 1, 1, 0));
        drive(vec("w_s9", 0, 0, 0, 0, 1, 0, 0, mk(B,H,E,L), 1, 1, 0));
        drive(vec("w_s10", 0, 0, 0, 0, 1, 0, 0, mk(H,E,L,L), 1, 1, 0));
        drive(vec("w_s11_new", 0, 0, 0, 0, 1, 0, 0, mk(E,L,L,O), 1, 1, 0));

        // Asynchronous reset in the middle of a running scroll.
        drive(vec("r_s12", 0, 0, 0, 0, 1, 0, 0, mk(L,L,O,B), 1, 1, 0));
        #2;
        reset = 0;
        #1;
        expect_now("rst_async", mk(B,B,B,B), 0, 0, 0);
        check_next();
        @(posedge clk); #1;
        expect_now("rst_held", mk(B,B,B,B), 0, 0, 0);
        check_next();
        reset = 1;
        @(posedge clk); #1;
        expect_now("rst_release", mk(B,B,B,B), 0, 0, 0);
        check_next();
        drive(vec("r_start", 1, 5, 1, 0, 0, 0, 0, mk(B,B,B,B), 1, 0, 0));
        drive(vec("r_s1", 0, 0, 0, 0, 1, 0, 0, mk(B,B,B,H), 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
